ir_prefetch_queue: RTL and testbench

- Parametrised successor to the single instruction register: a DEPTH-entry prefetch queue of memory-buffer words feeding a registered instruction register.
- The IR exposes opcode and address fields of the head instruction.
- Sits between the memory buffer register and the control unit. Memory fetch pushes words; the control unit advances (pops) on instruction retire and flushes on a taken jump.
- Adds buffering, a valid/ready handshake, field split, flush and an underflow flag; the single register has none of these.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/ir_fifo_mem.sv | 73 +++++++
 rtl/ir_prefetch_queue.sv | 110 +++++++++++
 tb/tb_ir_prefetch_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, instruction word layout and pointer sizing
package cpu_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int OPC_W_DEF  = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);

    // Default instruction word: opcode in the MSBs, address in the LSBs
    typedef struct packed {
        logic [OPC_W_DEF-1:0]  opcode;
        logic [ADDR_W_DEF-1:0] addr;
    } instr_t;

    // Pointer width for a queue of the given depth
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ir_fifo_mem.sv
// rtl/ir_fifo_mem.sv - DEPTH x WORD_W register-array queue with wrap-around pointers
module ir_fifo_mem
    import cpu_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wdata,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  count_next,
    output logic [WORD_W-1:0] head_word
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    // Next pointer/count/storage state; push and pop are pre-qualified by the caller
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = wdata;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Post-update head word, so a push into an empty queue is visible immediately
    assign head_word  = mem_d[head_d];
    assign count      = count_q;
    assign count_next = count_d;

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care after reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ir_prefetch_queue.sv
// rtl/ir_prefetch_queue.sv - prefetch queue feeding a registered instruction register
module ir_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int OPC_W  = OPC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [WORD_W-1:0] mbr_in,
    output logic              push_ready,
    input  logic              advance,
    input  logic              flush,
    output logic              ir_valid,
    output logic [OPC_W-1:0]  ir_opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              underflow
);

    if (OPC_W + ADDR_W > WORD_W) begin : g_bad_field_split
        $error("ir_prefetch_queue: OPC_W + ADDR_W must not exceed WORD_W");
    end

    logic              push_acc;
    logic              pop_acc;
    logic [CNT_W-1:0]  count_next;
    logic [WORD_W-1:0] head_word;
    logic              unused_word;

    logic              ir_valid_q, ir_valid_d;
    logic [OPC_W-1:0]  ir_opcode_q, ir_opcode_d;
    logic [ADDR_W-1:0] ir_addr_q, ir_addr_d;
    logic              underflow_q, underflow_d;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = !full;

    // Flush wins over both push and pop
    assign push_acc = push_valid && push_ready && !flush;
    assign pop_acc  = advance && !empty && !flush;

    ir_fifo_mem #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (flush),
        .push       (push_acc),
        .pop        (pop_acc),
        .wdata      (mbr_in),
        .count      (count),
        .count_next (count_next),
        .head_word  (head_word)
    );

    // Middle bits between opcode and address are intentionally ignored
    assign unused_word = ^head_word;

    // IR reload from the post-update head; fields hold their last value when the queue drains
    always_comb begin
        ir_valid_d  = ir_valid_q;
        ir_opcode_d = ir_opcode_q;
        ir_addr_d   = ir_addr_q;
        underflow_d = underflow_q;
        if (flush) begin
            ir_valid_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q | (advance & empty);
            if (count_next != '0) begin
                ir_valid_d  = 1'b1;
                ir_opcode_d = head_word[WORD_W-1 -: OPC_W];
                ir_addr_d   = head_word[ADDR_W-1:0];
            end else begin
                ir_valid_d  = 1'b0;
            end
        end
    end

    // IR and sticky underflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_valid_q  <= 1'b0;
            ir_opcode_q <= '0;
            ir_addr_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            ir_valid_q  <= ir_valid_d;
            ir_opcode_q <= ir_opcode_d;
            ir_addr_q   <= ir_addr_d;
            underflow_q <= underflow_d;
        end
    end

    assign ir_valid  = ir_valid_q;
    assign ir_opcode = ir_opcode_q;
    assign ir_addr   = ir_addr_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb/tb_ir_prefetch_queue.sv - randomized and directed check of ir_prefetch_queue against a queue model
module tb_ir_prefetch_queue;
    import cpu_pkg::*;

    localparam int WORD_W = 16;
    localparam int OPC_W  = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              push_valid;
    logic [WORD_W-1:0] mbr_in;
    logic              push_ready;
    logic              advance;
    logic              flush;
    logic              ir_valid;
    logic [OPC_W-1:0]  ir_opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              underflow;

    int errors = 0;
    int checks = 0;

    // Model state: queued words (head first), IR contents and sticky flag
    logic [WORD_W-1:0] mq[$];
    bit                m_irv;
    logic [WORD_W-1:0] m_irw;
    bit                m_uf;

    ir_prefetch_queue #(
        .WORD_W (WORD_W),
        .OPC_W  (OPC_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .mbr_in     (mbr_in),
        .push_ready (push_ready),
        .advance    (advance),
        .flush      (flush),
        .ir_valid   (ir_valid),
        .ir_opcode  (ir_opcode),
        .ir_addr    (ir_addr),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        instr_t w;
        w = m_irw;
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("push_ready", 32'(push_ready), 32'(mq.size() != DEPTH));
        chk("ir_valid", 32'(ir_valid), 32'(m_irv));
        chk("ir_opcode", 32'(ir_opcode), 32'(w.opcode));
        chk("ir_addr", 32'(ir_addr), 32'(w.addr));
        chk("underflow", 32'(underflow), 32'(m_uf));
    endtask

    // Drive one cycle, advance the model, then compare at the following falling edge
    task automatic cycle(input bit pv, input logic [WORD_W-1:0] w, input bit adv,
                         input bit fl, input bit rs);
        push_valid = pv;
        mbr_in     = w;
        advance    = adv;
        flush      = fl;
        rst        = rs;
        if (rs) begin
            mq.delete();
            m_irv = 0;
            m_irw = '0;
            m_uf  = 0;
        end else if (fl) begin
            mq.delete();
            m_irv = 0;
            m_uf  = 0;
        end else begin
            bit was_full;
            was_full = (mq.size() == DEPTH);
            if (adv && mq.size() == 0) m_uf = 1;
            if (adv && mq.size() > 0) void'(mq.pop_front());
            if (pv && !was_full) mq.push_back(w);
            if (mq.size() > 0) begin
                m_irv = 1;
                m_irw = mq[0];
            end else begin
                m_irv = 0;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, 0);
    endtask

    initial begin
        // Reset and idle
        cycle(0, '0, 0, 0, 1);
        idle();
        chk("lit_reset_empty", 32'(empty), 32'd1);
        chk("lit_reset_ready", 32'(push_ready), 32'd1);
        chk("lit_reset_irv", 32'(ir_valid), 32'd0);
        chk("lit_reset_opc", 32'(ir_opcode), 32'h00);
        chk("lit_reset_count", 32'(count), 32'd0);
        cycle(0, '0, 1, 0, 0);
        chk("lit_underflow_set", 32'(underflow), 32'd1);
        cycle(0, '0, 0, 1, 0);
        chk("lit_underflow_clr", 32'(underflow), 32'd0);

        // Single word through the IR
        cycle(1, 16'h1A2B, 0, 0, 0);
        chk("lit_first_irv", 32'(ir_valid), 32'd1);
        chk("lit_first_opc", 32'(ir_opcode), 32'h1A);
        chk("lit_first_addr", 32'(ir_addr), 32'h2B);
        chk("lit_first_count", 32'(count), 32'd1);
        cycle(0, '0, 1, 0, 0);
        chk("lit_drain_irv", 32'(ir_valid), 32'd0);
        chk("lit_drain_opc_hold", 32'(ir_opcode), 32'h1A);

        // Fill to full, refuse a fifth word, drain in order
        for (int i = 1; i <= 4; i++) cycle(1, 16'(i * 16'h0101), 0, 0, 0);
        chk("lit_full", 32'(full), 32'd1);
        chk("lit_full_ready", 32'(push_ready), 32'd0);
        cycle(1, 16'h0505, 0, 0, 0);
        chk("lit_refused_count", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("lit_drain_order", 32'(ir_opcode), 32'(i));
            cycle(0, '0, 1, 0, 0);
        end
        chk("lit_drained_empty", 32'(empty), 32'd1);

        // Interleaved push/pop across the pointer wrap
        for (int i = 0; i < 3; i++) cycle(1, 16'hA000 + 16'(i), 0, 0, 0);
        for (int i = 3; i < 6; i++) cycle(1, 16'hA000 + 16'(i), 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0);

        // Simultaneous push and pop at count 1
        cycle(0, '0, 0, 1, 0);
        cycle(1, 16'h5566, 0, 0, 0);
        chk("lit_simul_before", 32'(ir_opcode), 32'h55);
        cycle(1, 16'h7788, 1, 0, 0);
        chk("lit_simul_opc", 32'(ir_opcode), 32'h77);
        chk("lit_simul_count", 32'(count), 32'd1);

        // Flush beats push and advance
        cycle(1, 16'h1111, 0, 0, 0);
        cycle(1, 16'h2222, 0, 0, 0);
        cycle(1, 16'h9999, 1, 1, 0);
        chk("lit_flush_count", 32'(count), 32'd0);
        chk("lit_flush_irv", 32'(ir_valid), 32'd0);
        chk("lit_flush_ready", 32'(push_ready), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
